// File: rtl/conv_engine_arbiter_pkg.sv
// conv_engine_arbiter_pkg: FSM state encoding, defaults and clog2 helper shared by the arbiter files.
package conv_engine_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_RELEASE, ST_RESP} state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_CNT_W = 16;
  function automatic int clog2(input int n);
    int r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
endpackage

// File: rtl/conv_engine_arbiter_if.sv
// conv_engine_arbiter_if: requester and engine handshake bundle; master = clients/engine, slave = arbiter.
interface conv_engine_arbiter_if import conv_engine_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SEL_W = clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic rsp_err, eng_start, eng_done, eng_rst, busy;
  logic [SEL_W-1:0] eng_sel;
  modport master (
    output req_valid, rsp_ready, eng_done,
    input req_ready, rsp_valid, rsp_err, eng_start, eng_rst, eng_sel, busy
  );
  modport slave (
    input req_valid, rsp_ready, eng_done,
    output req_ready, rsp_valid, rsp_err, eng_start, eng_rst, eng_sel, busy
  );
endinterface

// File: rtl/conv_engine_arbiter_rr_arbiter.sv
// conv_engine_arbiter_rr_arbiter: combinational round-robin pick of the first request at/after ptr_i.
module conv_engine_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [SEL_W-1:0]   idx_o
);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  logic [SEL_W-1:0] j;
  // Scan from the farthest offset down so the closest set bit is written last.
  always_comb begin
    idx_o = '0;
    j = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = SEL_W'((int'(ptr_i) + k) % NUM_REQ);
      if (req_i[j]) idx_o = j;
    end
  end
  assign gnt_o = |req_i ? ONE << idx_o : '0;
endmodule

// File: rtl/conv_engine_arbiter.sv
// conv_engine_arbiter: round-robin sharing of one conv2d engine among NUM_REQ clients.
// Define WATCHDOG_EN to add the RUN timeout that resets the engine and answers with rsp_err.
module conv_engine_arbiter import conv_engine_arbiter_pkg::*; #(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int SEL_W = clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  conv_engine_arbiter_if.slave bus
);
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);
  if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cfg_chk
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end
  state_e state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d, sel_q, sel_d, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic start_q, start_d, erst_q, erst_d, err_q, err_d, grant, expired;
  conv_engine_arbiter_rr_arbiter #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_rr (
    .req_i(bus.req_valid),
    .ptr_i(rr_ptr_q),
    .gnt_o(win_gnt),
    .idx_o(win_idx)
  );
  assign grant = state_q == ST_IDLE && |bus.req_valid;
`ifdef WATCHDOG_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= (rst || grant) ? '0 : (state_q == ST_RUN) ? cnt_q + 1'b1 : cnt_q;
  end
  // A done seen on the expiry cycle takes priority, so the job still completes cleanly.
  assign expired = state_q == ST_RUN && !bus.eng_done && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_ptr_q <= '0;
      sel_q <= '0;
      start_q <= 1'b0;
      erst_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q <= sel_d;
      start_q <= start_d;
      erst_q <= erst_d;
      err_q <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = grant ? ST_RUN : ST_IDLE;
      ST_RUN:     state_d = bus.eng_done ? ST_RELEASE : expired ? ST_RESP : ST_RUN;
      ST_RELEASE: state_d = bus.eng_done ? ST_RELEASE : ST_RESP;
      ST_RESP:    state_d = bus.rsp_ready[sel_q] ? ST_IDLE : ST_RESP;
      default:    state_d = ST_IDLE;
    endcase
  end
  always_comb begin
    sel_d = grant ? win_idx : sel_q;
    rr_ptr_d = grant ? ((win_idx == SEL_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1) : rr_ptr_q;
    start_d = state_d == ST_RUN;
    erst_d = expired;
    err_d = grant ? 1'b0 : expired ? 1'b1 : err_q;
    bus.req_ready = (state_q == ST_IDLE) ? win_gnt : '0;
    bus.rsp_valid = (state_q == ST_RESP) ? ONE << sel_q : '0;
    bus.rsp_err = state_q == ST_RESP && err_q;
    bus.eng_start = start_q;
    bus.eng_rst = erst_q;
    bus.eng_sel = sel_q;
    bus.busy = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_conv_engine_arbiter.sv
// tb_conv_engine_arbiter: random clients and engine against a job-level reference model.
module tb_conv_engine_arbiter;
  localparam int N = 4;
  localparam int SW = 2;
  localparam int TO = 16;
`ifdef WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  conv_engine_arbiter_if #(.NUM_REQ(N), .SEL_W(SW)) bus ();
  conv_engine_arbiter #(.NUM_REQ(N), .SEL_W(SW), .TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_chk = 0, n_err = 0, cyc = 0;
  int owner = -1, ptr = 0, exp_sel = 0, run_cnt = 0;
  bit done_seen, released, err, rst_pulse;
  bit e_busy, done, prev_start, prev_rst;
  int e_cnt, e_hold;
  int p_req = 0, p_rdy = 100, max_lat = 3, hold_max = 5;
  logic [N-1:0] pend = '0, rdy = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] p, input int from);
    for (int k = 0; k < N; k++) if (p[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic step(input bit do_rst);
    int w;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (!pend[i] && $urandom_range(99) < p_req) pend[i] = 1'b1;
    for (int i = 0; i < N; i++) rdy[i] = $urandom_range(99) < p_rdy;
    if (prev_rst) begin
      e_busy = 1'b0;
      done = 1'b0;
    end else if (done) begin
      if (!prev_start) begin
        if (e_hold == 0) done = 1'b0;
        else e_hold--;
      end
    end else if (e_busy) begin
      if (e_cnt == 0) begin
        done = 1'b1;
        e_busy = 1'b0;
        e_hold = $urandom_range(hold_max);
      end else e_cnt--;
    end else if (prev_start) begin
      e_busy = 1'b1;
      e_cnt = $urandom_range(max_lat);
    end
    bus.req_valid = pend;
    bus.eng_done = done;
    bus.rsp_ready = rdy;
    rst = do_rst;
    #1;
    w = first_from(pend, ptr);
    check("req_ready", 32'(bus.req_ready), (owner < 0 && w >= 0) ? 32'(1) << w : 32'd0);
    check("busy", 32'(bus.busy), 32'(owner >= 0));
    check("eng_start", 32'(bus.eng_start), 32'(owner >= 0 && !done_seen));
    check("eng_sel", 32'(bus.eng_sel), 32'(exp_sel));
    check("rsp_valid", 32'(bus.rsp_valid), (owner >= 0 && released) ? 32'(1) << owner : 32'd0);
    check("rsp_err", 32'(bus.rsp_err), 32'(owner >= 0 && released && err));
    check("eng_rst", 32'(bus.eng_rst), 32'(rst_pulse));
    prev_start = bus.eng_start;
    prev_rst = bus.eng_rst || do_rst;
    rst_pulse = 1'b0;
    if (do_rst) begin
      owner = -1;
      ptr = 0;
      exp_sel = 0;
      done_seen = 1'b0;
      released = 1'b0;
      err = 1'b0;
    end else if (owner < 0) begin
      if (w >= 0) begin
        owner = w;
        exp_sel = w;
        ptr = (w + 1) % N;
        pend[w] = 1'b0;
        done_seen = 1'b0;
        released = 1'b0;
        err = 1'b0;
        run_cnt = 0;
      end
    end else if (!done_seen) begin
      if (done) done_seen = 1'b1;
      else begin
        run_cnt++;
        if (WD && run_cnt == TO) begin
          done_seen = 1'b1;
          released = 1'b1;
          err = 1'b1;
          rst_pulse = 1'b1;
        end
      end
    end else if (!released) begin
      if (!done) released = 1'b1;
    end else if (rdy[owner]) owner = -1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.eng_done = 1'b0;
    bus.rsp_ready = '0;
    repeat (3) step(1'b1);
    p_req = 100; p_rdy = 100; max_lat = 2;
    repeat (60) step(1'b0);
    p_req = 30; p_rdy = 50; max_lat = 6;
    repeat (1500) step(1'b0);
    p_rdy = 0;
    repeat (25) step(1'b0);
    p_rdy = 100;
    repeat (20) step(1'b0);
    p_req = 60;
    for (int i = 0; i < 200 && !(bus.busy && bus.eng_start); i++) step(1'b0);
    check("reach_run", 32'(bus.busy && bus.eng_start), 32'd1);
    step(1'b1);
    p_req = 100;
    repeat (40) step(1'b0);
    p_req = 40; p_rdy = 60; max_lat = 24;
    repeat (500) step(1'b0);
    max_lat = 6;
    repeat (800) step(1'b0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
